// File: rtl/bus_ack_fifo.sv
// Acknowledger end of a four-phase req/ack bus. Each handshake pushes one
// packet into a small FIFO, which is drained through a valid/ready pop port.
// ack is withheld while the FIFO is full, which stalls the requester.
module bus_ack_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [W-1:0]               data,
  output logic                       ack,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                rx_total,
  output logic                       proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StAcked} state_e;

  state_e          state_q;
  logic            ack_q;
  logic            stall_q;
  logic            err_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     rx_total_q;
  logic [W-1:0]    mem_q [DEPTH];

  logic pop;
  logic space;
  logic push;

  // Pop, space and capture decisions for the current cycle.
  always_comb begin
    pop   = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the slot the new packet lands in.
    space = (count_q < CW'(DEPTH)) || pop;
    push  = (state_q == StIdle) && req && space;
  end

  // Handshake FSM with registered ack, stall tracking and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Remember that a request was waiting on space last cycle.
      stall_q <= (state_q == StIdle) && req && !space;
      // Request withdrawn before it was ever acknowledged.
      if ((state_q == StIdle) && stall_q && !req) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= StAcked;
          end
        end
        StAcked: begin
          if (!req) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and accepted-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rx_total_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        rx_total_q <= rx_total_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Packet storage; contents need no reset since out_valid gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign ack       = ack_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign rx_total  = rx_total_q;
  assign proto_err = err_q;

endmodule
